// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
//   Shared definitions for the elevator front end.
//   - N_FLOORS             : number of call buttons / floors served
//   - DEBOUNCE_CYCLES_DEF  : default debounce window (10 ms at 50 MHz)
//   - deb_state_e          : per-button debounce FSM encoding
//   - cnt_width()          : debounce counter width, never narrower than 1 bit
// -----------------------------------------------------------------------------
package elevator_pkg;

  localparam int N_FLOORS            = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    REL    = 2'd0,  // debounced released
    WAIT_P = 2'd1,  // sampled pressed, waiting for it to be stable
    PRS    = 2'd2,  // debounced pressed
    WAIT_R = 2'd3   // sampled released, waiting for it to be stable
  } deb_state_e;

  // The counter only has to reach DEBOUNCE_CYCLES-1, so $clog2 of the
  // window is enough; clamp to 1 bit so a window of 1 or 2 still elaborates.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Conditions one raw push button: polarity normalisation, 2-flop
//   synchronizer, 4-state debounce FSM with a stability counter, and a
//   single-cycle press indication.
//
// Ports
//   clk_50       in   board clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   raw          in   raw button pin, asynchronous to clk_50
//   level        out  debounced level, 1 = pressed
//   press_strobe out  high for the one cycle in which the FSM accepts a press
//                     (combinational: the state register and any downstream
//                     register capture the press on the same edge)
// -----------------------------------------------------------------------------
module button_debounce
  import elevator_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_strobe
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          w_norm;
  logic          r_sync1;
  logic          r_sync2;
  deb_state_e    r_state;
  deb_state_e    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_strobe;

  // After this XOR, 1 always means pressed.
  assign w_norm = raw ^ BTN_ACTIVE_LOW;

  // Synchronizer flops reset to the normalised released level (0).
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_norm;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_strobe    = 1'b0;
    case (r_state)
      REL: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_P;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_P: begin
        if (!r_sync2) begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRS;
          w_cnt_nxt   = '0;
          w_strobe    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRS: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_R;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_R: begin
        if (r_sync2) begin
          w_state_nxt = PRS;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = REL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = REL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // WAIT_R still counts as pressed: the level only drops once the release
  // itself has been debounced.
  assign level        = (r_state == PRS) || (r_state == WAIT_R);
  assign press_strobe = w_strobe;

endmodule

// File: rtl/call_request_latch.sv
// -----------------------------------------------------------------------------
// call_request_latch
//   Front end of the elevator: debounces the three floor-call buttons and
//   keeps one sticky pending request per floor. A request is cleared when the
//   car stands at that floor with the door open; the clear wins over a press
//   arriving in the same cycle.
//
// Ports
//   clk_50            in   board clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   btn1..btn3        in   raw call buttons (asynchronous)
//   floor1..floor3    in   car-at-floor flags from the movement FSM
//   door              in   door-open flag from the movement FSM
//   req1..req3        out  pending call per floor (drive led1..led3)
//   req_any           out  registered OR of req1..req3
//   pressed[2:0]      out  one-cycle strobe per accepted press, bit i = floor i+1
// -----------------------------------------------------------------------------
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       floor1,
  input  logic       floor2,
  input  logic       floor3,
  input  logic       door,
  output logic       req1,
  output logic       req2,
  output logic       req3,
  output logic       req_any,
  output logic [2:0] pressed
);

  logic [N_FLOORS-1:0] w_raw;
  logic [N_FLOORS-1:0] w_floor;
  logic [N_FLOORS-1:0] w_strobe;
  logic [N_FLOORS-1:0] w_clr;
  logic [N_FLOORS-1:0] w_req_nxt;
  logic [N_FLOORS-1:0] r_req;
  logic                r_req_any;
  logic [N_FLOORS-1:0] r_pressed;

  assign w_raw   = {btn3, btn2, btn1};
  assign w_floor = {floor3, floor2, floor1};

  for (genvar g = 0; g < N_FLOORS; g++) begin : g_btn
    // The debounced level is not needed here; only the press event matters.
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_deb (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .raw          (w_raw[g]),
      .level        (),
      .press_strobe (w_strobe[g])
    );
  end

  // Clear has priority, so a press at the floor the car is standing at with
  // the door open is dropped rather than re-lighting the LED.
  always_comb begin
    w_clr     = w_floor & {N_FLOORS{door}};
    w_req_nxt = ~w_clr & (r_req | w_strobe);
  end

  // req_any is taken from the next-state vector so it moves on the same edge
  // as the individual requests instead of one cycle later.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= '0;
      r_req_any <= 1'b0;
      r_pressed <= '0;
    end else begin
      r_req     <= w_req_nxt;
      r_req_any <= |w_req_nxt;
      r_pressed <= w_strobe;
    end
  end

  assign req1    = r_req[0];
  assign req2    = r_req[1];
  assign req3    = r_req[2];
  assign req_any = r_req_any;
  assign pressed = r_pressed;

endmodule
